// File: rtl/score_record_scheduler.sv
// -----------------------------------------------------------------------------
// score_record_scheduler
//
// Sequential owner of the 4 users x 4 songs score record store used by
// learning mode. Score commits from the learning engine, store clears and
// per-user average recomputes all share the single store through one FSM.
// Each user's average is built over four accumulate cycles and a truncating
// divide by 4 rather than with a combinational 4-way add.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset (control and outputs only,
//                 the record store itself is only zeroed by clear)
//   commit        level, high while learning is finished; 0->1 edge commits
//   commit_user   user of the commit
//   commit_song   song of the commit
//   commit_score  score to record
//   clear         single-cycle pulse, zeroes all 16 records
//   sel_user      user selected for display
//   sel_song      song selected for display
//   rec_score     registered record[{sel_user,sel_song}], 1-cycle latency
//   avg_score     average of the 4 records of avg_user
//   avg_user      user that avg_score belongs to
//   avg_valid     avg_score is current for avg_user
//   busy          FSM not in IDLE
// -----------------------------------------------------------------------------
module score_record_scheduler #(
    parameter int SCORE_W   = 41,
    parameter bit KEEP_BEST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit,
    input  logic [1:0]         commit_user,
    input  logic [1:0]         commit_song,
    input  logic [SCORE_W-1:0] commit_score,
    input  logic               clear,
    input  logic [1:0]         sel_user,
    input  logic [1:0]         sel_song,
    output logic [SCORE_W-1:0] rec_score,
    output logic [SCORE_W-1:0] avg_score,
    output logic [1:0]         avg_user,
    output logic               avg_valid,
    output logic               busy
);

    localparam int ACC_W = SCORE_W + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_WR   = 3'd2,
        S_ACC  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // Truncating divide by 4 of the 4-entry sum.
    function automatic logic [SCORE_W-1:0] div4(input logic [ACC_W-1:0] sum);
        return SCORE_W'(sum >> 2);
    endfunction

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic               commit_prev_q, commit_prev_d;   // registered commit level
    logic [1:0]         slot_user_q, slot_user_d;       // commit waiting for / in WR
    logic [1:0]         slot_song_q, slot_song_d;
    logic [SCORE_W-1:0] slot_score_q, slot_score_d;
    logic [3:0]         idx_q, idx_d;                   // CLR entry / ACC song index
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]         acc_user_q, acc_user_d;
    logic [1:0]         sel_prev_q, sel_prev_d;
    logic               sel_prev_vld_q, sel_prev_vld_d; // 0 = reset marker
    logic [SCORE_W-1:0] rec_score_q, rec_score_d;
    logic [SCORE_W-1:0] avg_score_q, avg_score_d;
    logic [1:0]         avg_user_q, avg_user_d;
    logic               avg_valid_q, avg_valid_d;

    logic [SCORE_W-1:0] store_q [16];
    logic               st_we;
    logic [3:0]         st_waddr;
    logic [SCORE_W-1:0] st_wdata;

    logic commit_edge;
    logic sel_mismatch;
    logic enter_acc;
    logic out_done;

    assign commit_edge  = commit & ~commit_prev_q;
    // Until the first OUT, sel_prev holds no user, so a recompute is owed.
    assign sel_mismatch = ~sel_prev_vld_q | (sel_user != sel_prev_q);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic; clear preempts every state, including CLR itself.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLR;
                end else if (commit_edge || pending_q) begin
                    state_d = S_WR;
                end else if (sel_mismatch) begin
                    state_d = S_ACC;
                end
            end
            S_CLR: begin
                if (clear) begin
                    state_d = S_CLR;
                end else if (idx_q == 4'd15) begin
                    state_d = S_ACC;
                end
            end
            S_WR:  state_d = clear ? S_CLR : S_ACC;
            S_ACC: begin
                if (clear) begin
                    state_d = S_CLR;
                end else if (idx_q == 4'd3) begin
                    state_d = S_OUT;
                end
            end
            S_OUT:   state_d = clear ? S_CLR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and output next values
    // ---------------------------------------------------------------------
    always_comb begin
        commit_prev_d  = commit;
        pending_d      = pending_q;
        slot_user_d    = slot_user_q;
        slot_song_d    = slot_song_q;
        slot_score_d   = slot_score_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        acc_user_d     = acc_user_q;
        sel_prev_d     = sel_prev_q;
        sel_prev_vld_d = sel_prev_vld_q;
        avg_score_d    = avg_score_q;
        avg_user_d     = avg_user_q;
        avg_valid_d    = avg_valid_q;
        rec_score_d    = store_q[{sel_user, sel_song}];
        st_we          = 1'b0;
        st_waddr       = idx_q;
        st_wdata       = '0;

        enter_acc = (state_d == S_ACC) && (state_q != S_ACC);
        // OUT only publishes when it is not being aborted by clear.
        out_done  = (state_q == S_OUT) && (state_d == S_IDLE);

        // Index restarts on every state change and on every clear.
        if ((state_d != state_q) || clear) begin
            idx_d = '0;
        end else if ((state_q == S_CLR) || (state_q == S_ACC)) begin
            idx_d = idx_q + 4'd1;
        end

        // A commit edge is captured unless clear wins or the store is
        // being wiped; in IDLE it goes straight to WR, otherwise it waits.
        if (commit_edge && !clear && (state_q != S_CLR)) begin
            slot_user_d  = commit_user;
            slot_song_d  = commit_song;
            slot_score_d = commit_score;
        end

        if (clear) begin
            pending_d = 1'b0;
        end else if ((state_q == S_IDLE) && (state_d == S_WR)) begin
            pending_d = 1'b0;
        end else if (commit_edge && (state_q != S_IDLE) && (state_q != S_CLR)) begin
            pending_d = 1'b1;
        end

        if (state_q == S_CLR) begin
            st_we    = 1'b1;
            st_waddr = idx_q;
            st_wdata = '0;
        end else if ((state_q == S_WR) && !clear) begin
            st_waddr = {slot_user_q, slot_song_q};
            st_wdata = slot_score_q;
            st_we    = !KEEP_BEST || (slot_score_q > store_q[{slot_user_q, slot_song_q}]);
        end

        // After a write the committed user is averaged, otherwise sel_user.
        if (enter_acc) begin
            acc_d      = '0;
            acc_user_d = (state_q == S_WR) ? slot_user_q : sel_user;
        end else if (state_q == S_ACC) begin
            acc_d = acc_q + ACC_W'(store_q[{acc_user_q, idx_q[1:0]}]);
        end

        if (out_done) begin
            avg_score_d    = div4(acc_q);
            avg_user_d     = acc_user_q;
            sel_prev_d     = acc_user_q;
            sel_prev_vld_d = 1'b1;
        end

        if ((state_d == S_CLR) || enter_acc) begin
            avg_valid_d = 1'b0;
        end else if (out_done) begin
            avg_valid_d = 1'b1;
        end else if ((state_q == S_IDLE) && (sel_user != avg_user_q)) begin
            avg_valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // FSM outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    assign rec_score = rec_score_q;
    assign avg_score = avg_score_q;
    assign avg_user  = avg_user_q;
    assign avg_valid = avg_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q      <= 1'b0;
            commit_prev_q  <= 1'b0;
            idx_q          <= '0;
            sel_prev_q     <= '0;
            sel_prev_vld_q <= 1'b0;
            rec_score_q    <= '0;
            avg_score_q    <= '0;
            avg_user_q     <= '0;
            avg_valid_q    <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            commit_prev_q  <= commit_prev_d;
            idx_q          <= idx_d;
            sel_prev_q     <= sel_prev_d;
            sel_prev_vld_q <= sel_prev_vld_d;
            rec_score_q    <= rec_score_d;
            avg_score_q    <= avg_score_d;
            avg_user_q     <= avg_user_d;
            avg_valid_q    <= avg_valid_d;
        end
    end

    // Data registers: no reset, they are always loaded before use.
    always_ff @(posedge clk) begin
        slot_user_q  <= slot_user_d;
        slot_song_q  <= slot_song_d;
        slot_score_q <= slot_score_d;
        acc_q        <= acc_d;
        acc_user_q   <= acc_user_d;
    end

    // Record store: survives rst, zeroed only through CLR.
    always_ff @(posedge clk) begin
        if (st_we) begin
            store_q[st_waddr] <= st_wdata;
        end
    end

endmodule
